// File: rtl/ahbl_defs.sv
// rtl/ahbl_defs.sv - AHB-lite encodings shared by bus-facing blocks
package ahbl_defs;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF      = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/ahbl_cmd_master.sv
// rtl/ahbl_cmd_master.sv - valid/ready command stream to pipelined single AHB-lite transfers
import ahbl_defs::*;

module ahbl_cmd_master #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [W_DATA-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              idle,
  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [2:0]        ahblm_hburst,
  output logic [3:0]        ahblm_hprot,
  output logic              ahblm_hmastlock,
  output logic [W_DATA-1:0] ahblm_hwdata,
  input  logic              ahblm_hready,
  input  logic              ahblm_hresp,
  input  logic [W_DATA-1:0] ahblm_hrdata
);

  logic              a_vld_q, a_vld_d;
  logic [W_ADDR-1:0] a_addr_q, a_addr_d;
  logic              a_write_q, a_write_d;
  logic [2:0]        a_size_q, a_size_d;
  logic [W_DATA-1:0] a_wdata_q, a_wdata_d;
  logic              d_vld_q, d_vld_d;
  logic              d_write_q, d_write_d;
  logic [W_DATA-1:0] d_wdata_q, d_wdata_d;
  logic              cancel_pend_q, cancel_pend_d;

  logic err1;
  logic accept;

  // First cycle of the two-cycle ERROR response from the subordinate.
  assign err1   = d_vld_q && ahblm_hresp && !ahblm_hready;
  assign accept = cmd_valid && cmd_ready;

  assign cmd_ready = !cancel_pend_q && !err1 && (!a_vld_q || ahblm_hready);

  always_comb begin
    a_vld_d       = a_vld_q;
    a_addr_d      = a_addr_q;
    a_write_d     = a_write_q;
    a_size_d      = a_size_q;
    a_wdata_d     = a_wdata_q;
    d_vld_d       = d_vld_q;
    d_write_d     = d_write_q;
    d_wdata_d     = d_wdata_q;
    cancel_pend_d = cancel_pend_q;

    if (ahblm_hready) begin
      a_vld_d   = 1'b0;
      d_vld_d   = a_vld_q && !cancel_pend_q;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end

    if (accept) begin
      a_vld_d   = 1'b1;
      a_addr_d  = cmd_addr;
      a_write_d = cmd_write;
      a_size_d  = cmd_size;
      a_wdata_d = cmd_wdata;
    end

    // Pending cancel is answered once the errored transfer has left the data phase.
    if (err1 && a_vld_q) begin
      cancel_pend_d = 1'b1;
    end else if (cancel_pend_q && !d_vld_q) begin
      cancel_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q       <= 1'b0;
      a_addr_q      <= '0;
      a_write_q     <= 1'b0;
      a_size_q      <= '0;
      a_wdata_q     <= '0;
      d_vld_q       <= 1'b0;
      d_write_q     <= 1'b0;
      d_wdata_q     <= '0;
      cancel_pend_q <= 1'b0;
    end else begin
      a_vld_q       <= a_vld_d;
      a_addr_q      <= a_addr_d;
      a_write_q     <= a_write_d;
      a_size_q      <= a_size_d;
      a_wdata_q     <= a_wdata_d;
      d_vld_q       <= d_vld_d;
      d_write_q     <= d_write_d;
      d_wdata_q     <= d_wdata_d;
      cancel_pend_q <= cancel_pend_d;
    end
  end

  assign ahblm_htrans    = (a_vld_q && !cancel_pend_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahblm_haddr     = a_addr_q;
  assign ahblm_hwrite    = a_write_q;
  assign ahblm_hsize     = a_size_q;
  assign ahblm_hwdata    = d_wdata_q;
  assign ahblm_hburst    = HBURST_SINGLE;
  assign ahblm_hprot     = HPROT_DATA_PRIV;
  assign ahblm_hmastlock = 1'b0;

  assign rsp_valid = (d_vld_q && ahblm_hready) || (cancel_pend_q && !d_vld_q);
  assign rsp_err   = d_vld_q ? ahblm_hresp : cancel_pend_q;
  assign rsp_rdata = (d_vld_q && d_write_q) ? '0 : ahblm_hrdata;

  assign idle = !a_vld_q && !d_vld_q && !cancel_pend_q;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// tb/tb_ahbl_cmd_master.sv - self-checking bench for ahbl_cmd_master with an SRAM subordinate model
import ahbl_defs::*;

module tb_ahbl_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, idle;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp, hmastlock;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahbl_cmd_master #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .idle(idle),
    .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
    .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
    .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
    .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
  );

  // Zero/random-wait SRAM subordinate; contents default to a seeded pattern until written.
  logic [31:0] seed = 32'h1234_5678;
  logic [31:0] mem [256];
  bit          written [256];
  logic        dp_vld, dp_write;
  logic [7:0]  dp_idx;
  int unsigned wait_cnt;
  bit          rand_waits = 1'b0;
  logic        ovr_en = 1'b0, ovr_hready = 1'b1, ovr_hresp = 1'b0;
  logic        sram_ready;
  logic [31:0] sram_rdata;

  assign sram_ready = (wait_cnt == 0);
  assign sram_rdata = (dp_vld && !dp_write) ?
                      (written[dp_idx] ? mem[dp_idx] : (seed ^ (32'(dp_idx) * 32'h9E37_79B9))) : 32'h0;
  assign hready = ovr_en ? ovr_hready : sram_ready;
  assign hresp  = ovr_en ? ovr_hresp : 1'b0;
  assign hrdata = sram_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_vld <= 1'b0; dp_write <= 1'b0; dp_idx <= 8'h0; wait_cnt <= 0;
    end else if (hready) begin
      if (dp_vld && dp_write) begin
        mem[dp_idx]     <= hwdata;
        written[dp_idx] <= 1'b1;
      end
      dp_vld   <= (htrans == HTRANS_NONSEQ);
      dp_write <= hwrite;
      dp_idx   <= haddr[9:2];
      wait_cnt <= (rand_waits && htrans == HTRANS_NONSEQ) ? $urandom_range(0, 2) : 0;
    end else if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  function automatic logic [31:0] sram_word(int idx);
    return written[idx] ? mem[idx] : (seed ^ (32'(idx) * 32'h9E37_79B9));
  endfunction

  task automatic set_cmd(bit v, bit w, logic [31:0] a, logic [31:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = HSIZE_WORD;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cmd(0, 0, 32'h0, 32'h0);
    @(negedge clk); #1;
    n_tests++; if (htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL rst_htrans got=%0h exp=0", htrans); end
    n_tests++; if (haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr got=%0h exp=0", haddr); end
    n_tests++; if ({hwrite, hsize} !== 4'h0) begin n_fail++; $display("FAIL rst_hwrite_hsize got=%0h exp=0", {hwrite, hsize}); end
    n_tests++; if (hwdata !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata got=%0h exp=0", hwdata); end
    n_tests++; if ({cmd_ready, rsp_valid, rsp_err, idle} !== 4'b1001) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=1001", {cmd_ready, rsp_valid, rsp_err, idle}); end
    n_tests++; if ({hburst, hprot, hmastlock} !== 8'b000_0011_0) begin n_fail++; $display("FAIL rst_consts got=%b exp=00000110", {hburst, hprot, hmastlock}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_read_write();
    logic [31:0] exp_rd;
    exp_rd = sram_word(32'h100 >> 2);
    @(negedge clk); set_cmd(1, 0, 32'h100, 32'h0); #1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready got=%b exp=1", cmd_ready); end
    @(negedge clk); set_cmd(1, 1, 32'h104, 32'hDEAD_BEEF); #1;
    n_tests++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h100 || hwrite !== 1'b0) begin n_fail++; $display("FAIL rw_rd_aphase got=%0h/%0h/%b exp=2/100/0", htrans, haddr, hwrite); end
    @(negedge clk); set_cmd(0, 0, 32'h0, 32'h0); #1;
    n_tests++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h104 || hwrite !== 1'b1) begin n_fail++; $display("FAIL rw_wr_aphase got=%0h/%0h/%b exp=2/104/1", htrans, haddr, hwrite); end
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL rw_rd_rsp got=%b/%b/%0h exp=1/0/%0h", rsp_valid, rsp_err, rsp_rdata, exp_rd); end
    @(negedge clk); #1;
    n_tests++; if (htrans !== HTRANS_IDLE || hwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_wr_dphase got=%0h/%0h exp=0/deadbeef", htrans, hwdata); end
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rw_wr_rsp got=%b/%b exp=1/0", rsp_valid, rsp_err); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rw_end got=%b/%b exp=0/1", rsp_valid, idle); end
    n_tests++; if (sram_word(32'h104 >> 2) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_mem got=%0h exp=deadbeef", sram_word(32'h104 >> 2)); end
  endtask

  task automatic test_wait_states();
    logic [31:0] wd, exp_rd;
    wd = $urandom;
    exp_rd = sram_word(32'h300 >> 2);
    ovr_en = 1'b1; ovr_hready = 1'b1; ovr_hresp = 1'b0;
    @(negedge clk); set_cmd(1, 0, 32'h300, 32'h0);
    @(negedge clk); set_cmd(1, 1, 32'h308, wd); #1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ws_accept got=%b exp=1", cmd_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_cmd(1, 0, 32'h30C, 32'h0); ovr_hready = 1'b0; #1;
      n_tests++; if (haddr !== 32'h308 || htrans !== HTRANS_NONSEQ || hsize !== HSIZE_WORD || hwrite !== 1'b1) begin n_fail++; $display("FAIL ws_hold%0d got=%0h/%0h/%0h exp=308/2/2", k, haddr, htrans, hsize); end
      n_tests++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ws_stall%0d got=%b/%b exp=0/0", k, cmd_ready, rsp_valid); end
    end
    @(negedge clk); set_cmd(0, 0, 32'h0, 32'h0); ovr_hready = 1'b1; #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL ws_rd_rsp got=%b/%b/%0h exp=1/0/%0h", rsp_valid, rsp_err, rsp_rdata, exp_rd); end
    @(negedge clk); #1;
    n_tests++; if (hwdata !== wd || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ws_wr got=%0h/%b exp=%0h/1", hwdata, rsp_valid, wd); end
    @(negedge clk); #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ws_idle got=%b exp=1", idle); end
  endtask

  task automatic test_error_cancel();
    ovr_en = 1'b1; ovr_hready = 1'b1; ovr_hresp = 1'b0;
    @(negedge clk); set_cmd(1, 0, 32'h200, 32'h0);
    @(negedge clk); set_cmd(1, 1, 32'h204, 32'hCAFE_F00D);
    @(negedge clk); set_cmd(0, 0, 32'h0, 32'h0); ovr_hresp = 1'b1; ovr_hready = 1'b0; #1;
    n_tests++; if (htrans !== HTRANS_NONSEQ || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ec_err1 got=%0h/%b/%b exp=2/0/0", htrans, cmd_ready, rsp_valid); end
    @(negedge clk); ovr_hready = 1'b1; #1;
    n_tests++; if (htrans !== HTRANS_IDLE || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ec_err2_bus got=%0h/%b exp=0/0", htrans, cmd_ready); end
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL ec_err_rsp got=%b/%b exp=1/1", rsp_valid, rsp_err); end
    @(negedge clk); ovr_hresp = 1'b0; #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || htrans !== HTRANS_IDLE || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ec_cancel_rsp got=%b/%b/%0h/%b exp=1/1/0/0", rsp_valid, rsp_err, htrans, cmd_ready); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || idle !== 1'b1 || htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL ec_end got=%b/%b/%b exp=0/1/1", rsp_valid, cmd_ready, idle); end
    n_tests++; if (written[32'h204 >> 2] !== 1'b0) begin n_fail++; $display("FAIL ec_no_write got=%b exp=0", written[32'h204 >> 2]); end
    ovr_en = 1'b0;
  endtask

  task automatic test_error_no_pending();
    ovr_en = 1'b1; ovr_hready = 1'b1; ovr_hresp = 1'b0;
    @(negedge clk); set_cmd(1, 1, 32'h10, 32'h5555_AAAA);
    @(negedge clk); set_cmd(0, 0, 32'h0, 32'h0);
    @(negedge clk); ovr_hresp = 1'b1; ovr_hready = 1'b0; #1;
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL en_err1 got=%b/%b exp=0/0", rsp_valid, cmd_ready); end
    @(negedge clk); ovr_hready = 1'b1; #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL en_rsp got=%b/%b exp=1/1", rsp_valid, rsp_err); end
    @(negedge clk); ovr_hresp = 1'b0; #1;
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || idle !== 1'b1) begin n_fail++; $display("FAIL en_end got=%b/%b/%b exp=0/1/1", rsp_valid, cmd_ready, idle); end
    ovr_en = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_q[$];
    int issued = 0, got = 0, ns_cnt = 0, first = -1, last = -1;
    rand_waits = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      @(negedge clk);
      if (issued < 16) set_cmd(1, 0, 32'h40 + 32'(issued) * 4, 32'h0);
      else set_cmd(0, 0, 32'h0, 32'h0);
      #1;
      if (htrans == HTRANS_NONSEQ) begin ns_cnt++; if (first < 0) first = cyc; last = cyc; end
      if (rsp_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL st_extra_rsp got=%0h exp=none", rsp_rdata); end
        else if (rsp_rdata !== exp_q[0] || rsp_err !== 1'b0) begin n_fail++; $display("FAIL st_data%0d got=%0h exp=%0h", got, rsp_rdata, exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (cmd_valid && cmd_ready) begin exp_q.push_back(sram_word(16 + issued)); issued++; end
    end
    set_cmd(0, 0, 32'h0, 32'h0);
    n_tests++; if (got != 16) begin n_fail++; $display("FAIL st_count got=%0d exp=16", got); end
    n_tests++; if (ns_cnt != 16 || last - first + 1 != 16) begin n_fail++; $display("FAIL st_nonseq got=%0d span=%0d exp=16", ns_cnt, last - first + 1); end
    @(negedge clk); #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL st_idle got=%b exp=1", idle); end
  endtask

  typedef struct packed { logic w; logic [31:0] d; } exp_t;

  task automatic test_random();
    exp_t q[$];
    logic [31:0] model [16];
    int issued = 0, got = 0;
    bit w; logic [3:0] ix; logic [31:0] wd;
    rand_waits = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = sram_word(32'h80 + i);
    w = 1'($urandom); ix = 4'($urandom); wd = $urandom;
    for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
      @(negedge clk);
      set_cmd((issued < 40) && ($urandom_range(0, 3) != 0), w, {22'h0, 4'h8, ix, 2'b00}, wd);
      #1;
      if (rsp_valid) begin
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rnd_extra_rsp got=%0h exp=none", rsp_rdata); end
        else if (rsp_err !== 1'b0 || (!q[0].w && rsp_rdata !== q[0].d)) begin n_fail++; $display("FAIL rnd_rsp%0d got=%b/%0h exp=0/%0h", got, rsp_err, rsp_rdata, q[0].d); end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (cmd_valid && cmd_ready) begin
        if (w) model[ix] = wd;
        q.push_back({w, model[ix]});
        issued++;
        w = 1'($urandom); ix = 4'($urandom); wd = $urandom;
      end
    end
    set_cmd(0, 0, 32'h0, 32'h0);
    n_tests++; if (got != 40 || q.size() != 0) begin n_fail++; $display("FAIL rnd_count got=%0d left=%0d exp=40/0", got, q.size()); end
    rand_waits = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rnd_idle got=%b exp=1", idle); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); set_cmd(1, 0, 32'h40, 32'h0);
    @(negedge clk); set_cmd(1, 0, 32'h44, 32'h0);
    @(negedge clk); set_cmd(0, 0, 32'h0, 32'h0); #1;
    n_tests++; if (htrans !== HTRANS_NONSEQ || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ar_busy got=%0h/%b exp=2/1", htrans, rsp_valid); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (htrans !== HTRANS_IDLE || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || idle !== 1'b1) begin n_fail++; $display("FAIL ar_async got=%0h/%b/%b/%b exp=0/0/1/1", htrans, rsp_valid, cmd_ready, idle); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (idle !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_after got=%b/%b exp=1/0", idle, rsp_valid); end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_read_write();
    test_wait_states();
    test_error_cancel();
    test_error_no_pending();
    test_streaming();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_cmd_master.md
Name: ahbl_cmd_master

Overview:
- AHB-lite manager (initiator). Converts a simple valid/ready command stream into single AHB-lite transfers (HBURST=SINGLE).
- Address phase of command N+1 overlaps data phase of command N, so back-to-back commands sustain one transfer per cycle against zero-wait-state subordinates such as our SRAM adapters.
- Returns one response per command, in order: read data or error.
- Sits between a simple requester (debug module, DMA, test driver) and the bus fabric.

Parameters:
W_ADDR, 32, address width
W_DATA, 32, data width; multiple of 8, 32 in this design

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous assert, active-high (already decided)
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid && ready
cmd_addr  input  W_ADDR  byte address
cmd_write  input  1  1 = write, 0 = read
cmd_size  input  3  HSIZE encoding
cmd_wdata  input  W_DATA  write data, already placed on the correct byte lanes by the requester
rsp_valid  output  1  one-cycle pulse per completed command; no backpressure
rsp_rdata  output  W_DATA  read data, valid with rsp_valid on reads
rsp_err  output  1  transfer errored or was cancelled
idle  output  1  no command in address or data phase and no response pending
ahblm_haddr  output  W_ADDR  bus address
ahblm_hwrite  output  1  bus write
ahblm_htrans  output  2  IDLE (00) or NONSEQ (10) only
ahblm_hsize  output  3  bus size
ahblm_hburst  output  3  constant 000
ahblm_hprot  output  4  constant 0011
ahblm_hmastlock  output  1  constant 0
ahblm_hwdata  output  W_DATA  write data during data phase
ahblm_hready  input  1  bus ready
ahblm_hresp  input  1  bus error response
ahblm_hrdata  input  W_DATA  read data

Behaviour:
- State registers:
  - A-phase: a_vld, a_addr, a_write, a_size, a_wdata.
  - D-phase: d_vld, d_write, d_wdata.
  - cancel_pend.
- Reset clears all registers. Outputs at reset: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, cmd_ready=1, rsp_valid=0, rsp_err=0, idle=1.
- Address-phase outputs come from registers:
  - htrans = (a_vld && !cancel) ? NONSEQ : IDLE.
  - haddr, hwrite and hsize come from the A regs.
  - hwdata = d_wdata.
- cmd_ready = !cancel_pend && !err1 && (!a_vld || ahblm_hready).
  - err1 = d_vld && hresp && !hready, the first cycle of the two-cycle error response.
- On cmd_valid && cmd_ready: load the A regs, set a_vld. cmd_addr sees one cycle of latency before reaching haddr.
- A NONSEQ transfer is held stable until hready=1. The only exception is error cancel.
- When hready=1:
  - d_vld <= a_vld (and not cancelled); d_write and d_wdata are copied from the A regs.
  - a_vld <= 0 unless a new command loads in the same cycle.
- Response (combinational from the bus):
  - rsp_valid = d_vld && hready; rsp_rdata = hrdata; rsp_err = hresp.
  - For writes, rsp_rdata is don't-care.
- Error handling:
  - On err1 with a_vld=1: mark the A-phase command cancelled. htrans becomes IDLE from the next cycle, which is the second error cycle.
  - The errored command's response appears on the second error cycle with rsp_err=1.
  - On the cycle after that, the cancelled command's response appears: rsp_valid=1, rsp_err=1, driven from cancel_pend.
  - cmd_ready stays 0 from err1 through the cancel response.
  - Responses therefore stay in order and never collide.
- Error with a_vld=0: no cancel; single error response only.
- Write data is presented for the whole data phase, including wait states.
- Sizes and alignment are not checked; they are forwarded unmodified.
- idle = !a_vld && !d_vld && !cancel_pend.
- Reset mid-operation: all state is abandoned with no response. The fabric is reset by the same rst.

Decomposition:
- Shared package (ahbl_defs): HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE, HPROT_DATA_PRIV (0011).
- No sub-module; single flat module.

Test Plan:
- Read then write, zero-wait subordinate:
  - Stimulus: cmd read @0x100, then write 0xDEADBEEF @0x104, on consecutive cycles.
  - Required: htrans NONSEQ on 2 consecutive cycles; hwdata=0xDEADBEEF in the cycle after the write's A-phase; 2 rsp pulses; read rsp_rdata equals the SRAM value.
- Wait states:
  - Stimulus: subordinate holds hready=0 for 3 cycles during a read's data phase, with a write queued in A-phase.
  - Required: haddr, htrans and hsize stable for all 3 cycles; cmd_ready=0; rsp_valid only on the 4th cycle.
- Error with cancel:
  - Stimulus: read @0x200 gets hresp=1/hready=0, then hresp=1/hready=1, with a write @0x204 pending.
  - Required: htrans=IDLE in the second error cycle; errored rsp_err=1, then the cancel response rsp_err=1 next cycle; no write is issued.
- Error without pending command:
  - Stimulus: a single write errors.
  - Required: exactly one rsp with rsp_err=1; cmd_ready returns to 1 the next cycle.
- Streaming:
  - Stimulus: 16 back-to-back word reads against the ahb_sync_sram model.
  - Required: 16 NONSEQ cycles with no IDLE gaps; rsp data matches preload; idle=1 afterwards.
- Async reset mid-transfer:
  - Stimulus: assert rst with a_vld=1 and d_vld=1.
  - Required: htrans=IDLE, rsp_valid=0 and cmd_ready=1 immediately, without waiting for a clock edge.
